// File: rtl/io_event_frontend.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : io_event_frontend
// Brief    : Synchronizes board reset/interrupt/input-strobe events and drives
//            the processor's reset_signal, intr_signal and in_port.
// Revision : 1.0 - initial release
// ============================================================================
module io_event_frontend #(
    parameter int SYNC_STAGES      = 2,
    parameter int RST_PULSE_CYCLES = 1,
    parameter int INTR_GUARD       = 8,
    parameter int DATA_W           = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ext_reset_req,
    input  logic              ext_intr_req,
    input  logic              intr_enable,
    input  logic              ext_in_valid,
    input  logic [DATA_W-1:0] ext_in_data,
    output logic              reset_signal,
    output logic              intr_signal,
    output logic [DATA_W-1:0] in_port,
    output logic              intr_pending,
    output logic              intr_overrun,
    output logic              guard_busy
);
    localparam int c_CNT_MAX = (RST_PULSE_CYCLES > INTR_GUARD) ? RST_PULSE_CYCLES : INTR_GUARD;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_RST_LOAD   = c_CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GUARD_LOAD = c_CNT_W'(INTR_GUARD - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_RESET_PULSE = 2'd1,
        ST_INTR_PULSE  = 2'd2,
        ST_GUARD       = 2'd3
    } state_t;

    // Bit order in every sync stage: {reset, intr, valid}
    logic [SYNC_STAGES-1:0][2:0] r_sync;
    logic [2:0]                  r_prev;
    logic [2:0]                  w_sync;
    logic [2:0]                  w_rise;
    logic                        w_reset_rise;
    logic                        w_valid_rise;
    logic                        w_intr_req;
    logic                        w_issue;
    state_t                      r_state;
    logic [c_CNT_W-1:0]          r_cnt;

    assign w_sync       = r_sync[SYNC_STAGES-1];
    assign w_rise       = w_sync & ~r_prev;
    assign w_reset_rise = w_rise[2];
    assign w_valid_rise = w_rise[0];
    assign w_intr_req   = w_rise[1] & intr_enable & (r_state != ST_RESET_PULSE);

    // Pending request is consumed on this edge (IDLE, or GUARD expiring)
    assign w_issue = intr_pending &
                     ((r_state == ST_IDLE) || ((r_state == ST_GUARD) && (r_cnt == '0)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], {ext_reset_req, ext_intr_req, ext_in_valid}};
            r_prev <= w_sync;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_port <= '0;
        end else if (w_valid_rise) begin
            in_port <= ext_in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            reset_signal <= 1'b0;
            intr_signal  <= 1'b0;
            guard_busy   <= 1'b0;
            intr_pending <= 1'b0;
            intr_overrun <= 1'b0;
        end else if (w_reset_rise) begin
            r_state      <= ST_RESET_PULSE;
            r_cnt        <= c_RST_LOAD;
            reset_signal <= 1'b1;
            intr_signal  <= 1'b0;
            guard_busy   <= 1'b0;
            intr_pending <= 1'b0;
        end else begin
            reset_signal <= 1'b0;
            intr_signal  <= 1'b0;
            guard_busy   <= 1'b0;
            // Depth-one request latch; an edge landing on a consuming cycle is kept
            intr_pending <= (intr_pending & ~w_issue) | w_intr_req;
            if (w_intr_req && intr_pending && !w_issue) begin
                intr_overrun <= 1'b1;
            end
            case (r_state)
                ST_RESET_PULSE: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt        <= r_cnt - c_CNT_ONE;
                        reset_signal <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (intr_pending) begin
                        r_state     <= ST_INTR_PULSE;
                        intr_signal <= 1'b1;
                    end
                end
                ST_INTR_PULSE: begin
                    r_state    <= ST_GUARD;
                    r_cnt      <= c_GUARD_LOAD;
                    guard_busy <= 1'b1;
                end
                ST_GUARD: begin
                    if (r_cnt != '0) begin
                        r_cnt      <= r_cnt - c_CNT_ONE;
                        guard_busy <= 1'b1;
                    end else if (intr_pending) begin
                        // Skip the idle cycle so issue spacing is exactly INTR_GUARD+1
                        r_state     <= ST_INTR_PULSE;
                        intr_signal <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_event_frontend.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_io_event_frontend
// Brief    : Directed self-checking bench for io_event_frontend.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_event_frontend;
    logic       clk = 1'b0;
    logic       rst;
    logic       ext_reset_req;
    logic       ext_intr_req;
    logic       intr_enable;
    logic       ext_in_valid;
    logic [7:0] ext_in_data;

    logic       reset_signal, intr_signal, intr_pending, intr_overrun, guard_busy;
    logic [7:0] in_port;
    logic       rs3, is3, ip3, ov3, gb3;
    logic [7:0] port3;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulse  = 0;
    int base     = 0;
    bit mon_en   = 1'b0;

    always #5 clk = ~clk;

    io_event_frontend #(
        .SYNC_STAGES(2), .RST_PULSE_CYCLES(1), .INTR_GUARD(8), .DATA_W(8)
    ) dut (
        .clk(clk), .rst(rst), .ext_reset_req(ext_reset_req), .ext_intr_req(ext_intr_req),
        .intr_enable(intr_enable), .ext_in_valid(ext_in_valid), .ext_in_data(ext_in_data),
        .reset_signal(reset_signal), .intr_signal(intr_signal), .in_port(in_port),
        .intr_pending(intr_pending), .intr_overrun(intr_overrun), .guard_busy(guard_busy)
    );

    io_event_frontend #(
        .SYNC_STAGES(2), .RST_PULSE_CYCLES(3), .INTR_GUARD(8), .DATA_W(8)
    ) dut3 (
        .clk(clk), .rst(rst), .ext_reset_req(ext_reset_req), .ext_intr_req(ext_intr_req),
        .intr_enable(intr_enable), .ext_in_valid(ext_in_valid), .ext_in_data(ext_in_data),
        .reset_signal(rs3), .intr_signal(is3), .in_port(port3),
        .intr_pending(ip3), .intr_overrun(ov3), .guard_busy(gb3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] outs1();
        return {19'b0, reset_signal, intr_signal, intr_pending, intr_overrun, guard_busy, in_port};
    endfunction

    function automatic logic [31:0] outs3();
        return {19'b0, rs3, is3, ip3, ov3, gb3, port3};
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            check("excl_rst_intr", 32'(reset_signal & intr_signal), 0);
            if (intr_signal === 1'b1) n_pulse++;
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ext_reset_req = 1'b0; ext_intr_req = 1'b0;
        intr_enable = 1'b0; ext_in_valid = 1'b0; ext_in_data = 8'h00;
        step(2);
        rst = 1'b0;
        mon_en = 1'b1;

        // Post-reset idle
        check("reset_state", outs1(), 0);
        check("reset_state3", outs3(), 0);
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("idle_quiet", outs1(), 0);
        end

        // Single interrupt, level held high
        intr_enable = 1'b1;
        ext_intr_req = 1'b1;
        step(3);
        check("t2_pending", 32'(intr_pending), 1);
        check("t2_no_pulse_yet", 32'(intr_signal), 0);
        step(1);
        base = n_pulse;
        check("t2_pulse", 32'(intr_signal), 1);
        check("t2_pend_clr", 32'(intr_pending), 0);
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("t2_guard_busy", 32'(guard_busy), 1);
            check("t2_guard_no_pulse", 32'(intr_signal), 0);
        end
        step(1);
        check("t2_guard_done", 32'(guard_busy), 0);
        step(10);
        check("t2_one_pulse", 32'(n_pulse - base), 1);
        ext_intr_req = 1'b0;
        step(4);

        // Guard spacing and overrun
        base = n_pulse;
        ext_intr_req = 1'b1; step(1); ext_intr_req = 1'b0; step(3);
        check("t3_pulse1", 32'(intr_signal), 1);
        step(2); ext_intr_req = 1'b1; step(1); ext_intr_req = 1'b0; step(2);
        check("t3_pend2", 32'(intr_pending), 1);
        check("t3_guard", 32'(guard_busy), 1);
        check("t3_no_ovr_yet", 32'(intr_overrun), 0);
        ext_intr_req = 1'b1; step(1); ext_intr_req = 1'b0; step(2);
        check("t3_overrun", 32'(intr_overrun), 1);
        check("t3_still_pend", 32'(intr_pending), 1);
        check("t3_no_early_pulse", 32'(intr_signal), 0);
        step(1);
        check("t3_pulse2_at_9", 32'(intr_signal), 1);
        check("t3_pend_clr", 32'(intr_pending), 0);
        step(20);
        check("t3_two_pulses", 32'(n_pulse - base), 2);
        check("t3_ovr_sticky", 32'(intr_overrun), 1);

        // Reset pre-empts GUARD with a pending request
        ext_intr_req = 1'b1; step(1); ext_intr_req = 1'b0; step(3);
        check("t4_pulse", 32'(intr_signal), 1);
        step(2); ext_intr_req = 1'b1; step(1); ext_intr_req = 1'b0; step(2);
        check("t4_pend_in_guard", 32'(intr_pending), 1);
        ext_reset_req = 1'b1;
        step(2);
        check("t4_rst_not_yet", 32'(reset_signal), 0);
        check("t4_guard_before", 32'(guard_busy), 1);
        step(1);
        base = n_pulse;
        check("t4_rst_high", 32'(reset_signal), 1);
        check("t4_intr_low", 32'(intr_signal), 0);
        check("t4_pend_clr", 32'(intr_pending), 0);
        check("t4_guard_abort", 32'(guard_busy), 0);
        check("t4_ovr_kept", 32'(intr_overrun), 1);
        check("t4_rs3_c1", 32'(rs3), 1);
        step(1);
        check("t4_rst_one_cycle", 32'(reset_signal), 0);
        check("t4_rs3_c2", 32'(rs3), 1);
        check("t4_is3_low", 32'(is3), 0);
        step(1);
        check("t4_rs3_c3", 32'(rs3), 1);
        step(1);
        check("t4_rs3_done", 32'(rs3), 0);
        check("t4_ip3_clr", 32'(ip3), 0);
        step(10);
        check("t4_no_pulse", 32'(n_pulse - base), 0);
        check("t4_rst_oneshot", 32'(reset_signal), 0);
        ext_reset_req = 1'b0;
        step(4);

        // Input port capture on valid rise only
        ext_in_data = 8'hA5; ext_in_valid = 1'b1;
        step(2);
        check("t5_port_before", 32'(in_port), 0);
        step(1);
        check("t5_port_a5", 32'(in_port), 32'h A5);
        check("t5_port3_a5", 32'(port3), 32'h A5);
        step(1);
        ext_in_valid = 1'b0; ext_in_data = 8'h3C;
        step(6);
        check("t5_port_held", 32'(in_port), 32'h A5);
        ext_in_valid = 1'b1;
        step(3);
        check("t5_port_3c", 32'(in_port), 32'h 3C);
        ext_in_valid = 1'b0;
        step(3);

        // Enable gating, then rst during INTR_PULSE
        intr_enable = 1'b0;
        base = n_pulse;
        ext_intr_req = 1'b1; step(1); ext_intr_req = 1'b0; step(3);
        check("t6_gated_pend", 32'(intr_pending), 0);
        step(4);
        check("t6_gated_no_pulse", 32'(n_pulse - base), 0);
        intr_enable = 1'b1;
        ext_intr_req = 1'b1; step(1); ext_intr_req = 1'b0; step(3);
        check("t6_pulse", 32'(intr_signal), 1);
        rst = 1'b1;
        step(1);
        check("t6_rst_outs", outs1(), 0);
        check("t6_rst_outs3", outs3(), 0);
        rst = 1'b0;
        base = n_pulse;
        step(12);
        check("t6_after_rst", outs1(), 0);
        check("t6_after_rst_pulses", 32'(n_pulse - base), 0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/io_event_frontend.md
Name: io_event_frontend

Overview:
- Upstream front-end for the processor top. Conditions raw external events into the processor's `reset_signal`, `intr_signal` and `in_port` inputs.
- Synchronizes the external reset button, interrupt request and input-port handshake. Edge-detects them and drives a clean one-shot reset pulse and a one-cycle interrupt pulse.
- Enforces a guard window between interrupts so that a second interrupt cannot hit the pipeline while a previous one is still draining.
- Sits between board-level I/O and the processor. It is the only driver of those three processor inputs.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of every input synchronizer chain; minimum 2.
- RST_PULSE_CYCLES, 1: number of cycles `reset_signal` stays high per reset request; minimum 1.
- INTR_GUARD, 8: number of cycles after an issued interrupt during which no new interrupt is issued; minimum 1.
- DATA_W, 8: input-port data width.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ext_reset_req  in  1  asynchronous level from the board reset button.
- ext_intr_req  in  1  asynchronous interrupt request level; a rising edge means one request.
- intr_enable  in  1  synchronous; when 0, new interrupt edges are discarded.
- ext_in_valid  in  1  asynchronous strobe level from the input device.
- ext_in_data  in  DATA_W  input-device data; must be stable while `ext_in_valid` is high.
- reset_signal  out  1  registered; drives the processor's `reset_signal`.
- intr_signal  out  1  registered; one-cycle pulse that drives the processor's `intr_signal`.
- in_port  out  DATA_W  registered; drives the processor's `in_port`.
- intr_pending  out  1  an interrupt has been latched and not yet issued.
- intr_overrun  out  1  sticky; an interrupt edge arrived while one was already pending.
- guard_busy  out  1  high while the FSM is in GUARD.

Behaviour:
- Reset (`rst`=1 at a rising edge):
  - All synchronizer chains and edge-detect history registers are cleared to 0.
  - FSM goes to IDLE and all counters are cleared.
  - All outputs are 0, including `in_port`=0 and `intr_overrun`=0.
  - Holding `rst` during any state aborts that state immediately.
- Synchronizers:
  - Each of `ext_reset_req`, `ext_intr_req` and `ext_in_valid` passes through a SYNC_STAGES chain.
  - Edge detect compares the chain output with a one-cycle-delayed copy; `rise` = out & ~prev.
  - `ext_in_data` is not synchronized. It is captured only on a synchronized valid rise.
- Input port:
  - On `valid_rise`, `in_port` <= `ext_in_data` at the same edge.
  - Otherwise `in_port` holds its value.
  - The port is unaffected by the FSM and by `reset_signal`; only `rst` clears it.
- Pending latch:
  - `intr_rise` & `intr_enable` sets `intr_pending`.
  - If `intr_pending` is already 1, `intr_pending` stays 1 and `intr_overrun` is set. The request depth is one.
  - `intr_pending` clears when the FSM enters INTR_PULSE.
  - Entering RESET_PULSE clears `intr_pending`; `intr_overrun` is kept.
- FSM states: IDLE, RESET_PULSE, INTR_PULSE, GUARD.
  - Any state: `reset_rise` moves the FSM to RESET_PULSE and loads the counter with RST_PULSE_CYCLES-1. This has highest priority and pre-empts INTR_PULSE and GUARD.
  - RESET_PULSE:
    - `reset_signal`=1 and `intr_signal`=0.
    - Interrupt edges during this state are discarded.
    - The counter decrements; at 0 the FSM goes to IDLE.
  - IDLE: if `intr_pending`, go to INTR_PULSE.
  - INTR_PULSE:
    - `intr_signal`=1 for exactly one cycle.
    - Next state is GUARD, with the counter loaded with INTR_GUARD-1.
  - GUARD:
    - `guard_busy`=1.
    - New edges may set `intr_pending`, but issue waits.
    - The counter decrements; at 0 the FSM goes to IDLE.
  - `reset_signal` and `intr_signal` are never high in the same cycle.
- Latency (k = first rising edge at which the raw input is sampled high, S = SYNC_STAGES):
  - Reset path: `reset_signal` is high after edge k+S.
  - Interrupt path: `intr_pending` is high after edge k+S, and `intr_signal` after edge k+S+1, assuming the FSM is in IDLE.
  - Valid path: `in_port` is updated at edge k+S.
- Holding any request level high produces exactly one event. A new event requires the level to go low for at least one synchronized cycle, then high again.
- Back-to-back issue: with the default INTR_GUARD=8, consecutive `intr_signal` pulses are at least 9 cycles apart (INTR_GUARD+1).
- Counter widths: clog2(max(RST_PULSE_CYCLES, INTR_GUARD)+1) bits. Counters never wrap.

Test Plan:
- Post-reset idle: assert `rst` for 2 cycles, then hold all inputs low for 20 cycles → all outputs 0 throughout.
- Single interrupt (S=2, `intr_enable`=1): raise `ext_intr_req` before edge 10 and hold it → `intr_pending`=1 after edge 12 and `intr_signal`=1 only in the cycle after edge 13 → `guard_busy`=1 for the next 8 cycles. No second pulse while the level stays high.
- Guard and overrun: three request edges 3 cycles apart, starting at the first `intr_signal` pulse → the second edge is pended and issued exactly 9 cycles after the first pulse. The third edge arrives while the second is still pending → `intr_overrun`=1. Exactly two `intr_signal` pulses in total.
- Reset pre-empts: in GUARD with `intr_pending`=1, raise `ext_reset_req` → `reset_signal`=1 for RST_PULSE_CYCLES (test with 1 and 3) with `intr_signal`=0 → `intr_pending`=0 → IDLE, and `intr_overrun` is unchanged.
- Input port: `ext_in_data`=8'hA5 with `ext_in_valid` pulsed high for 4 cycles → `in_port`=8'hA5 after edge k+2 and held. Changing data to 8'h3C without a new valid edge leaves `in_port`=8'hA5.
- Enable gating and mid-operation reset: with `intr_enable`=0, an interrupt edge → no pending and no pulse. Assert `rst` during INTR_PULSE → next cycle all outputs 0, FSM in IDLE and `in_port`=0.
